axis_packet_snooper: RTL

//  Passive tap on an AXI-Stream link; copies each packet into the filter's packet memory

---
 rtl/axis_packet_snooper_if.sv | 24 ++
 rtl/axis_packet_snooper.sv | 131 +++++++++++++
 2 files changed

// File: rtl/axis_packet_snooper_if.sv
// AXI-Stream signal bundle for the tapped link feeding axis_packet_snooper.
// The snooper only observes the link, so its slave modport is input-only.
interface axis_packet_snooper_if #(
  parameter int DATA_WIDTH = 64
);
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tready;
  logic                  tlast;

  modport master (
    output tdata,
    output tvalid,
    output tready,
    output tlast
  );

  modport slave (
    input tdata,
    input tvalid,
    input tready,
    input tlast
  );
endinterface

// File: rtl/axis_packet_snooper.sv
// Passive AXI-Stream tap: copies each packet into the filter's packet memory
// through the snooper write port and signals completion with a 1-cycle done.
// Never back-pressures the link; packets arriving while the filter has no free
// buffer are dropped whole and counted in a saturating counter.
module axis_packet_snooper #(
  parameter int SNOOP_FWD_ADDR_WIDTH = 9,
  parameter int DATA_WIDTH           = 64,
  parameter int DROP_CNT_WIDTH       = 16
) (
  input  logic                            axi_aclk,
  input  logic                            axi_aresetn,
  axis_packet_snooper_if.slave            s_axis,
  input  logic                            ready_for_snooper,
  output logic [SNOOP_FWD_ADDR_WIDTH-1:0] snooper_wr_addr,
  output logic [DATA_WIDTH-1:0]           snooper_wr_data,
  output logic                            snooper_wr_en,
  output logic                            snooper_done,
  input  logic                            drop_clr,
  output logic [DROP_CNT_WIDTH-1:0]       num_packets_dropped,
  output logic                            truncated
);

  typedef enum logic [1:0] {SYNC, IDLE, CAPTURE, DROP} state_t;

  state_t                          state_q, state_d;
  logic                            beat;
  logic                            first_wr;
  logic                            cont_beat;
  logic                            drop_inc;
  logic                            pkt_end;
  logic                            done_sched;
  logic                            full;
  logic [SNOOP_FWD_ADDR_WIDTH-1:0] addr_cnt;

  assign beat = s_axis.tvalid & s_axis.tready;

  // State register.
  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) state_q <= SYNC;
    else              state_q <= state_d;
  end

  // Next-state and per-beat control decode.
  always_comb begin
    state_d   = state_q;
    first_wr  = 1'b0;
    cont_beat = 1'b0;
    drop_inc  = 1'b0;
    pkt_end   = 1'b0;
    unique case (state_q)
      SYNC: begin
        if (beat && s_axis.tlast) state_d = IDLE;
      end
      IDLE: begin
        if (beat) begin
          if (ready_for_snooper) begin
            first_wr = 1'b1;
            pkt_end  = s_axis.tlast;
            state_d  = s_axis.tlast ? IDLE : CAPTURE;
          end else begin
            drop_inc = 1'b1;
            state_d  = s_axis.tlast ? IDLE : DROP;
          end
        end
      end
      CAPTURE: begin
        if (beat) begin
          cont_beat = 1'b1;
          if (s_axis.tlast) begin
            pkt_end = 1'b1;
            state_d = IDLE;
          end
        end
      end
      DROP: begin
        if (beat && s_axis.tlast) state_d = IDLE;
      end
      default: state_d = SYNC;
    endcase
  end

  // Registered write port; done is delayed one extra cycle so it follows the final write.
  // 'full' marks that the last buffer word has been written, so later beats are discarded
  // instead of wrapping the address counter.
  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      snooper_wr_en   <= 1'b0;
      snooper_wr_addr <= '0;
      snooper_wr_data <= '0;
      snooper_done    <= 1'b0;
      done_sched      <= 1'b0;
      addr_cnt        <= '0;
      full            <= 1'b0;
    end else begin
      snooper_wr_en <= 1'b0;
      done_sched    <= pkt_end;
      snooper_done  <= done_sched;
      if (first_wr) begin
        snooper_wr_en   <= 1'b1;
        snooper_wr_addr <= '0;
        snooper_wr_data <= s_axis.tdata;
        addr_cnt        <= SNOOP_FWD_ADDR_WIDTH'(1);
        full            <= 1'b0;
      end else if (cont_beat && !full) begin
        snooper_wr_en   <= 1'b1;
        snooper_wr_addr <= addr_cnt;
        snooper_wr_data <= s_axis.tdata;
        addr_cnt        <= addr_cnt + 1'b1;
        full            <= &addr_cnt;
      end
    end
  end

  // Sticky overflow flag; clear wins over a simultaneous overflowing beat.
  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn)           truncated <= 1'b0;
    else if (drop_clr)          truncated <= 1'b0;
    else if (cont_beat && full) truncated <= 1'b1;
  end

  // Saturating drop counter; clear wins over a simultaneous increment.
  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn)
      num_packets_dropped <= '0;
    else if (drop_clr)
      num_packets_dropped <= '0;
    else if (drop_inc && !(&num_packets_dropped))
      num_packets_dropped <= num_packets_dropped + 1'b1;
  end

endmodule
